// File: rtl/rf_sequencer.sv
// Initiator-side controller for the 8x16 register file: accepts one instruction
// per valid/ready handshake, reads two operands, computes an ALU result and commits it.
module rf_sequencer #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic [AW-1:0] rf_rd_adrs_a,
    output logic [AW-1:0] rf_rd_adrs_b,
    input  logic [DW-1:0] rf_oper_a,
    input  logic [DW-1:0] rf_oper_b,
    output logic [AW-1:0] rf_wt_adrs,
    output logic [DW-1:0] rf_wt_data,
    output logic          rf_write,
    output logic          rf_step,
    output logic          done,
    output logic          busy,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_n,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7,
        OP_SHR  = 4'h8, OP_ADDI = 4'h9, OP_LDI = 4'hA, OP_MOV = 4'hB
    } op_t;

    state_t        state, stateNext;
    logic [15:0]   instrQ;
    logic [DW-1:0] operA, operB, resultQ;
    logic [AW-1:0] rdQ;
    logic          nextZ, nextC, nextN;
    logic          doneQ, zQ, cQ, nQ, errQ;
    logic [DW:0]   aluWide;
    logic [DW-1:0] immS, immZ;
    op_t           op;
    logic          isLegal, writes;

    assign op      = op_t'(instrQ[15:12]);
    assign isLegal = (instrQ[15:12] <= 4'hB);
    assign writes  = isLegal && (instrQ[15:12] != 4'h0);
    assign immS    = {{(DW-6){instrQ[5]}}, instrQ[5:0]};
    assign immZ    = {{(DW-9){1'b0}}, instrQ[8:0]};

    // Bit DW of aluWide is the carry/borrow/shifted-out bit for every op.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        aluWide = '0;
        case (op)
            OP_ADD:  aluWide = {1'b0, operA} + {1'b0, operB};
            OP_SUB:  aluWide = {1'b0, operA} - {1'b0, operB};
            OP_AND:  aluWide = {1'b0, operA & operB};
            OP_OR:   aluWide = {1'b0, operA | operB};
            OP_XOR:  aluWide = {1'b0, operA ^ operB};
            OP_NOT:  aluWide = {1'b0, ~operA};
            OP_SHL:  aluWide = {operA, 1'b0};
            OP_SHR:  aluWide = {operA[0], 1'b0, operA[DW-1:1]};
            OP_ADDI: aluWide = {1'b0, operA} + {1'b0, immS};
            OP_LDI:  aluWide = {1'b0, immZ};
            OP_MOV:  aluWide = {1'b0, operA};
            default: aluWide = '0;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (in_valid) stateNext = FETCH;
            FETCH:   stateNext = EXEC;
            EXEC:    stateNext = WB;
            WB:      stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrQ  <= '0;
            operA   <= '0;
            operB   <= '0;
            resultQ <= '0;
            rdQ     <= '0;
            nextZ   <= 1'b0;
            nextC   <= 1'b0;
            nextN   <= 1'b0;
            doneQ   <= 1'b0;
            zQ      <= 1'b0;
            cQ      <= 1'b0;
            nQ      <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            doneQ <= (state == WB);
            case (state)
                IDLE: if (in_valid) instrQ <= in_instr;
                FETCH: begin
                    operA <= rf_oper_a;
                    operB <= rf_oper_b;
                end
                EXEC: begin
                    resultQ <= aluWide[DW-1:0];
                    rdQ     <= instrQ[11:9];
                    nextZ   <= (aluWide[DW-1:0] == '0);
                    nextC   <= aluWide[DW];
                    nextN   <= aluWide[DW-1];
                end
                WB: begin
                    // Flags commit together with the register write; non-writing ops keep the old flags.
                    if (writes) begin
                        zQ <= nextZ;
                        cQ <= nextC;
                        nQ <= nextN;
                    end
                    if (!isLegal) errQ <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write strobes decode straight from state, so reset drops them without waiting for a clock.
    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign rf_step      = (state == WB);
    assign rf_write     = (state == WB) && writes;
    assign rf_rd_adrs_a = instrQ[8:6];
    assign rf_rd_adrs_b = instrQ[5:3];
    assign rf_wt_adrs   = rdQ;
    assign rf_wt_data   = resultQ;
    assign done         = doneQ;
    assign flag_z       = zQ;
    assign flag_c       = cQ;
    assign flag_n       = nQ;
    assign err          = errQ;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer: a reference model pushes expected commits,
// a monitor pops and compares them at each WB and done cycle.
module tb_rf_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic [2:0]  rf_rd_adrs_a, rf_rd_adrs_b, rf_wt_adrs;
    logic [15:0] rf_oper_a, rf_oper_b, rf_wt_data;
    logic        rf_write, rf_step, done, busy, flag_z, flag_c, flag_n, err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        write;
        logic [2:0]  adrs;
        logic [15:0] data;
        logic        z, c, n, e;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    bit   pendValid = 1'b0;

    logic [15:0] refReg[8];
    logic        refZ, refC, refN, refErr;

    rf_sequencer #(.DW(16), .AW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .rf_rd_adrs_a(rf_rd_adrs_a), .rf_rd_adrs_b(rf_rd_adrs_b),
        .rf_oper_a(rf_oper_a), .rf_oper_b(rf_oper_b),
        .rf_wt_adrs(rf_wt_adrs), .rf_wt_data(rf_wt_data), .rf_write(rf_write), .rf_step(rf_step),
        .done(done), .busy(busy), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .err(err)
    );

    always #5 clk = ~clk;

    // The 8x16 register file the sequencer drives.
    logic [15:0] rfMem[8];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rfMem[i] <= '0;
        end else if (rf_step && rf_write) begin
            rfMem[rf_wt_adrs] <= rf_wt_data;
        end
    end
    assign rf_oper_a = rfMem[rf_rd_adrs_a];
    assign rf_oper_b = rfMem[rf_rd_adrs_b];

    always @(negedge clk) begin
        if (!rst) begin
            if (rf_write && !rf_step) begin
                vectors++; miscompares++;
                $display("FAIL write_without_step: rf_write=1 rf_step=0");
            end
            if (rf_step) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_step: rf_step=1 rf_write=%0b with nothing outstanding", rf_write);
                end else begin
                    pend = q.pop_front();
                    pendValid = 1'b1;
                    if (rf_write !== pend.write) begin
                        miscompares++;
                        $display("FAIL wb_write: got %0b want %0b", rf_write, pend.write);
                    end else if (pend.write && (rf_wt_adrs !== pend.adrs || rf_wt_data !== pend.data)) begin
                        miscompares++;
                        $display("FAIL wb_data: got r%0d=%h want r%0d=%h",
                                 rf_wt_adrs, rf_wt_data, pend.adrs, pend.data);
                    end
                end
            end
            if (done) begin
                vectors++;
                if (!pendValid) begin
                    miscompares++;
                    $display("FAIL unexpected_done: done without a WB cycle");
                end else if ({flag_z, flag_c, flag_n, err, in_ready} !== {pend.z, pend.c, pend.n, pend.e, 1'b1}) begin
                    miscompares++;
                    $display("FAIL done_flags: got zcn/err/rdy=%b want %b",
                             {flag_z, flag_c, flag_n, err, in_ready}, {pend.z, pend.c, pend.n, pend.e, 1'b1});
                end
                pendValid = 1'b0;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) refReg[i] = '0;
        refZ = 0; refC = 0; refN = 0; refErr = 0;
        q.delete();
        pendValid = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] ins);
        logic [3:0]  op;
        logic [15:0] a, b, r, imm;
        logic        c, w;
        int          s;
        exp_t        e;
        op = ins[15:12];
        a = refReg[ins[8:6]];
        b = refReg[ins[5:3]];
        imm = {{10{ins[5]}}, ins[5:0]};
        r = '0; c = 1'b0; w = 1'b1;
        case (op)
            4'h1: begin s = int'(a) + int'(b); r = s[15:0]; c = (s > 65535); end
            4'h2: begin r = a - b; c = (a < b); end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: r = ~a;
            4'h7: begin r = a << 1; c = a[15]; end
            4'h8: begin r = a >> 1; c = a[0]; end
            4'h9: begin s = int'(a) + int'(imm); r = s[15:0]; c = (s > 65535); end
            4'hA: r = {7'b0, ins[8:0]};
            4'hB: r = a;
            default: w = 1'b0;
        endcase
        if (w) begin
            refReg[ins[11:9]] = r;
            refZ = (r == 16'h0); refC = c; refN = r[15];
        end
        if (op > 4'hB) refErr = 1'b1;
        e.write = w; e.adrs = ins[11:9]; e.data = r;
        e.z = refZ; e.c = refC; e.n = refN; e.e = refErr;
        q.push_back(e);
    endtask

    // Present one instruction, wait for acceptance, check the read addresses in FETCH and EXEC.
    task automatic issue(input logic [15:0] ins, input bit hold, output time acceptAt);
        int n = 0;
        acceptAt = 0;
        model_push(ins);
        in_valid = 1'b1;
        in_instr = ins;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: in_ready=0 want 1 for instr %h", ins);
            void'(q.pop_back());
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acceptAt = $time;
        #1;
        in_instr = ~ins;
        in_valid = hold;
        vectors++;
        if ({busy, in_ready, rf_rd_adrs_a, rf_rd_adrs_b} !== {1'b1, 1'b0, ins[8:6], ins[5:3]}) begin
            miscompares++;
            $display("FAIL fetch_adrs: got busy/rdy/a/b=%b want %b",
                     {busy, in_ready, rf_rd_adrs_a, rf_rd_adrs_b}, {1'b1, 1'b0, ins[8:6], ins[5:3]});
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({rf_rd_adrs_a, rf_rd_adrs_b, in_ready} !== {ins[8:6], ins[5:3], 1'b0}) begin
            miscompares++;
            $display("FAIL exec_adrs: got a/b/rdy=%b want %b",
                     {rf_rd_adrs_a, rf_rd_adrs_b, in_ready}, {ins[8:6], ins[5:3], 1'b0});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || pendValid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (q.size() != 0 || pendValid) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d commits outstanding, want 0", q.size());
            q.delete();
            pendValid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({in_ready, busy, done, rf_write, rf_step, flag_z, flag_c, flag_n, err} !== 9'b1_0000_0000 ||
            {rf_rd_adrs_a, rf_rd_adrs_b, rf_wt_adrs, rf_wt_data} !== 25'h0) begin
            miscompares++;
            $display("FAIL %s: got ctl=%b adrs/data=%h want ctl=100000000 adrs/data=0", tag,
                     {in_ready, busy, done, rf_write, rf_step, flag_z, flag_c, flag_n, err},
                     {rf_rd_adrs_a, rf_rd_adrs_b, rf_wt_adrs, rf_wt_data});
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_ldi();
        time t;
        issue(16'hA205, 1'b0, t);
        issue(16'hA403, 1'b0, t);
        drain();
        vectors++;
        if ({rfMem[1], rfMem[2]} !== {16'h0005, 16'h0003}) begin
            miscompares++;
            $display("FAIL ldi_regs: got r1=%h r2=%h want 0005 0003", rfMem[1], rfMem[2]);
        end
    endtask

    task automatic test_alu();
        time t;
        issue(16'h1650, 1'b0, t);
        issue(16'h2888, 1'b0, t);
        issue(16'h9A7F, 1'b0, t);
        drain();
        vectors++;
        if ({rfMem[3], rfMem[4], rfMem[5]} !== {16'h0008, 16'hFFFE, 16'h0004}) begin
            miscompares++;
            $display("FAIL alu_regs: got r3=%h r4=%h r5=%h want 0008 FFFE 0004", rfMem[3], rfMem[4], rfMem[5]);
        end
        vectors++;
        if ({flag_z, flag_c, flag_n} !== 3'b010) begin
            miscompares++;
            $display("FAIL addi_flags: got zcn=%b want 010", {flag_z, flag_c, flag_n});
        end
    endtask

    task automatic test_back_to_back();
        time t0, t1;
        issue(16'h0000, 1'b1, t0);
        issue(16'hF000, 1'b0, t1);
        drain();
        vectors++;
        if (t1 - t0 != 40) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0t want 40", t1 - t0);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({err, flag_z, flag_c, flag_n, busy} !== 5'b1_010_0) begin
            miscompares++;
            $display("FAIL err_sticky: got err/zcn/busy=%b want 10100", {err, flag_z, flag_c, flag_n, busy});
        end
    endtask

    task automatic test_reset_mid();
        time t;
        in_valid = 1'b1;
        in_instr = 16'h1C48;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid_release");
        issue(16'h1FB0, 1'b0, t);
        drain();
        vectors++;
        if ({rfMem[6], rfMem[7], flag_z} !== {16'h0, 16'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL post_reset_regs: got r6=%h r7=%h z=%b want 0000 0000 1", rfMem[6], rfMem[7], flag_z);
        end
    endtask

    task automatic test_rd_eq_rs();
        time t;
        issue(16'hA300, 1'b0, t);
        for (int i = 0; i < 7; i++) issue(16'h7240, 1'b0, t);
        issue(16'hA401, 1'b0, t);
        issue(16'h1250, 1'b0, t);
        drain();
        vectors++;
        if (rfMem[1] !== 16'h8001) begin
            miscompares++;
            $display("FAIL build_8001: got r1=%h want 8001", rfMem[1]);
        end
        issue(16'h7240, 1'b0, t);
        drain();
        vectors++;
        if ({rfMem[1], flag_c, flag_n, flag_z} !== {16'h0002, 3'b100}) begin
            miscompares++;
            $display("FAIL shl_rd_eq_rs: got r1=%h cnz=%b want 0002 100", rfMem[1], {flag_c, flag_n, flag_z});
        end
    endtask

    task automatic test_random();
        time t;
        logic [15:0] ins;
        for (int i = 0; i < 40; i++) begin
            ins = 16'($urandom);
            issue(ins, (i != 39) ? 1'b1 : 1'b0, t);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_back_to_back();
        test_reset_mid();
        test_rd_eq_rs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
